// File: rtl/uart_tx_fifo.sv
// Byte FIFO between uart_rx and uart_tx: buffers write strobes and launches bytes
// on baud ticks through a start/busy handshake with a small launch FSM.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  input  logic              tick,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [1:0]        fsm_state
);

  // Handshake: wr_valid is a one-clk strobe with no back-pressure (dropped and
  // flagged by overflow when full); tx_start is a one-clk request, tx_busy high
  // means uart_tx owns the byte, and no new launch happens until it falls.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              ack_tick_q, ack_tick_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [7:0]        mem_q [DEPTH];
  logic              push;
  logic              pop;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_tick_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_tick_q <= ack_tick_d;
    end
  end

  // Next-state logic; ACK gives up after the second tick without busy
  always_comb begin
    state_d    = state_q;
    ack_tick_d = ack_tick_q;
    case (state_q)
      IDLE: begin
        if (tick && !empty_q && !tx_busy) state_d = START;
      end
      START: begin
        state_d    = ACK;
        ack_tick_d = 1'b0;
      end
      ACK: begin
        if (tx_busy) begin
          state_d = DRAIN;
        end else if (tick) begin
          if (ack_tick_q) state_d = IDLE;
          else            ack_tick_d = 1'b1;
        end
      end
      DRAIN: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx_start  = (state_q == START);
    fsm_state = state_q;
  end

  assign pop  = (state_q == IDLE) && tick && !empty_q && !tx_busy;
  assign push = wr_valid && (!full_q || pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    tx_data_d  = pop  ? mem_q[rd_ptr_q] : tx_data_q;
    overflow_d = wr_valid && full_q && !pop;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + ONE_C;
    else if (pop && !push) count_d = count_q - ONE_C;
    full_d     = (count_d == DEPTH_C);
    empty_d    = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign tx_data  = tx_data_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios, expected bytes queued at write time
// and checked by a monitor on every tx_start pulse.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       tick;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [1:0] fsm_state;

  logic       man_tick = 1'b0;
  logic       auto_tick = 1'b0;
  logic       auto_en = 1'b0;
  logic       man_busy = 1'b0;
  logic       model_busy = 1'b0;
  logic       model_en = 1'b0;
  logic [1:0] tick_div = 2'd0;
  int         busy_cnt = 0;
  int         ovf_cnt = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];

  assign tick    = man_tick | auto_tick;
  assign tx_busy = model_en ? model_busy : man_busy;

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .tick(tick),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Baud tick generator: one pulse every 4 clocks when enabled
  always @(negedge clk) begin
    tick_div  = tick_div + 2'd1;
    auto_tick = auto_en && (tick_div == 2'd0);
  end

  // Behavioural uart_tx: busy for 6 clocks after each start pulse
  always @(negedge clk) begin
    if (rst) begin
      model_busy = 1'b0;
      busy_cnt   = 0;
    end else if (model_en && tx_start) begin
      model_busy = 1'b1;
      busy_cnt   = 6;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_busy = 1'b0;
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && overflow) ovf_cnt++;
    if (!rst && tx_start) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL tx_unexpected: got %0h expected none", tx_data);
      end else begin
        check("tx_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic write_byte(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    exp_q.push_back(d);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    man_tick = 1'b1;
    @(negedge clk);
    man_tick = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && fsm_state == 2'd0 && empty) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int ovf_base;
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_count", {27'd0, count}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);

    // Single byte
    write_byte(8'hA5);
    check("single_count1", {27'd0, count}, 32'd1);
    check("single_empty0", {31'd0, empty}, 32'd0);
    repeat (2) @(negedge clk);
    pulse_tick();
    check("single_start", {31'd0, tx_start}, 32'd1);
    check("single_data", {24'd0, tx_data}, 32'hA5);
    check("single_count0", {27'd0, count}, 32'd0);
    check("single_st_start", {30'd0, fsm_state}, 32'd1);
    @(negedge clk);
    check("single_st_ack", {30'd0, fsm_state}, 32'd2);
    check("single_start_pulse", {31'd0, tx_start}, 32'd0);
    man_busy = 1'b1;
    @(negedge clk);
    check("single_st_drain", {30'd0, fsm_state}, 32'd3);
    man_busy = 1'b0;
    @(negedge clk);
    check("single_st_idle", {30'd0, fsm_state}, 32'd0);
    check("single_data_held", {24'd0, tx_data}, 32'hA5);

    // No-busy timeout
    write_byte(8'h11);
    write_byte(8'h22);
    check("tmo_count2", {27'd0, count}, 32'd2);
    pulse_tick();
    check("tmo_start1", {31'd0, tx_start}, 32'd1);
    @(negedge clk);
    pulse_tick();
    check("tmo_ack_after1", {30'd0, fsm_state}, 32'd2);
    pulse_tick();
    check("tmo_idle_after2", {30'd0, fsm_state}, 32'd0);
    check("tmo_no_start", {31'd0, tx_start}, 32'd0);
    pulse_tick();
    check("tmo_start2", {31'd0, tx_start}, 32'd1);
    check("tmo_data2", {24'd0, tx_data}, 32'h22);
    @(negedge clk);
    pulse_tick();
    pulse_tick();
    check("tmo_idle_end", {30'd0, fsm_state}, 32'd0);

    // Order and pointer wrap with concurrent draining
    ovf_base = ovf_cnt;
    model_en = 1'b1;
    auto_en  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write_byte(i[7:0]);
      repeat (3) @(negedge clk);
    end
    wait_drain("wrap_drain");
    check("wrap_no_overflow", ovf_cnt - ovf_base, 32'd0);
    auto_en  = 1'b0;
    repeat (8) @(negedge clk);
    model_en = 1'b0;

    // Overflow: 17 writes, no ticks
    ovf_base = ovf_cnt;
    for (int i = 0; i < 17; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h40 + i[7:0];
      if (i < 16) exp_q.push_back(wr_data);
      @(negedge clk);
      if (i == 14) check("ovf_full_at15", {31'd0, full}, 32'd0);
      if (i == 15) begin
        check("ovf_full_at16", {31'd0, full}, 32'd1);
        check("ovf_count16", {27'd0, count}, 32'd16);
        check("ovf_none_yet", {31'd0, overflow}, 32'd0);
      end
      if (i == 16) begin
        check("ovf_pulse", {31'd0, overflow}, 32'd1);
        check("ovf_count_held", {27'd0, count}, 32'd16);
      end
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("ovf_pulse_end", {31'd0, overflow}, 32'd0);
    check("ovf_one_pulse", ovf_cnt - ovf_base, 32'd1);

    // Push and pop in the same clock while full
    man_tick = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    exp_q.push_back(8'hEE);
    @(negedge clk);
    man_tick = 1'b0;
    wr_valid = 1'b0;
    check("pp_start", {31'd0, tx_start}, 32'd1);
    check("pp_count16", {27'd0, count}, 32'd16);
    check("pp_full", {31'd0, full}, 32'd1);
    check("pp_no_overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    model_en = 1'b1;
    auto_en  = 1'b1;
    wait_drain("pp_drain");
    auto_en  = 1'b0;
    repeat (8) @(negedge clk);

    // Reset in the middle of a burst
    for (int i = 0; i < 5; i++) write_byte(8'h90 + i[7:0]);
    pulse_tick();
    check("mid_start", {31'd0, tx_start}, 32'd1);
    check("mid_count4", {27'd0, count}, 32'd4);
    rst = 1'b1;
    #1;
    check("mid_rst_count", {27'd0, count}, 32'd0);
    check("mid_rst_empty", {31'd0, empty}, 32'd1);
    check("mid_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
    check("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    check("mid_rst_state", {30'd0, fsm_state}, 32'd0);
    exp_q.delete();
    model_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pulse_tick();
    check("post_rst_no_launch", {31'd0, tx_start}, 32'd0);
    check("post_rst_count", {27'd0, count}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
